pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the enable and flush inputs of the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, EX-stage redirects, instruction- and data-memory wait states, and debug halt (ebreak drain). It also keeps stall/flush performance counters and a data-memory watchdog.

---
 rtl/rv_pipe_pkg.sv | 16 +
 rtl/pipeline_ctrl_hazard_detect.sv | 32 +++
 rtl/pipeline_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the 5-stage RISC-V pipeline control logic.
package rv_pipe_pkg;

  localparam int REG_ADDR_W       = 5;
  localparam int DEF_MEM_TIMEOUT  = 64;
  localparam int DEF_DRAIN_CYCLES = 3;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALT     = 3'd3,
    FAULT    = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
  import rv_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  logic [REG_ADDR_W-1:0] src_addr [2];
  logic [1:0]            src_use;
  logic [1:0]            src_hit;

  assign src_addr[0] = id_rs1;
  assign src_addr[1] = id_rs2;
  assign src_use     = {id_use_rs2, id_use_rs1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_use[gi] & (src_addr[gi] == ex_rd);
    end
  endgenerate

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read & (ex_rd != '0) & (|src_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the PC and IF/ID, ID/EX, EX/MEM registers, with
// dmem watchdog, debug halt drain, and stall/redirect performance counters.
module pipeline_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT  = DEF_MEM_TIMEOUT,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_redirect,
  input  logic                  imem_ready,
  input  logic                  mem_req,
  input  logic                  dmem_ready,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  halted,
  output logic                  fault,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           redirect_count
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  ctrl_state_t        state_reg, state_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;
  logic [31:0]        stall_cycles_reg;
  logic [15:0]        redirect_count_reg;

  logic       load_use, mem_stall;
  logic [3:0] run_en, en;
  logic       run_if_flush, run_id_flush, run_stall, run_redirect, run_halt;
  logic       if_flush, id_flush, redirect_inc, stall_inc;

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign mem_stall = mem_req & ~dmem_ready;

  // Enable vectors are ordered {pc, if_id, id_ex, ex_mem}.
  always_comb begin : run_decode
    run_en       = 4'b1111;
    run_if_flush = 1'b0;
    run_id_flush = 1'b0;
    run_stall    = 1'b0;
    run_redirect = 1'b0;
    run_halt     = 1'b0;
    if (mem_stall) begin
      run_en    = 4'b0000;
      run_stall = 1'b1;
    end else if (ex_redirect) begin
      run_if_flush = 1'b1;
      run_id_flush = 1'b1;
      run_redirect = 1'b1;
    end else if (load_use) begin
      run_en       = 4'b0011;
      run_id_flush = 1'b1;
    end else if (halt_req) begin
      run_en       = 4'b0111;
      run_if_flush = 1'b1;
      run_id_flush = 1'b1;
      run_halt     = 1'b1;
    end else if (!imem_ready) begin
      run_en       = 4'b0111;
      run_if_flush = 1'b1;
    end
  end

  always_comb begin : fsm_decode
    en             = 4'b0000;
    if_flush       = 1'b0;
    id_flush       = 1'b0;
    redirect_inc   = 1'b0;
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      RUN, MEM_WAIT: begin
        if (state_reg == MEM_WAIT && !dmem_ready) begin
          // The cycle that entered MEM_WAIT already counts as the first not-ready cycle.
          if (wait_cnt_reg == WAIT_LAST) state_next = FAULT;
          else wait_cnt_next = wait_cnt_reg + 1'b1;
        end else begin
          en           = run_en;
          if_flush     = run_if_flush;
          id_flush     = run_id_flush;
          redirect_inc = run_redirect;
          state_next   = RUN;
          if (run_stall) begin
            state_next    = MEM_WAIT;
            wait_cnt_next = WAIT_W'(1);
          end else if (run_halt) begin
            state_next     = DRAIN;
            drain_cnt_next = '0;
          end
        end
      end
      DRAIN: begin
        en       = mem_stall ? 4'b0100 : 4'b0111;
        if_flush = 1'b1;
        if (!mem_stall) begin
          if (drain_cnt_reg == DRAIN_LAST) state_next = HALT;
          else drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      HALT:    if (resume) state_next = RUN;
      FAULT:   state_next = FAULT;
      default: state_next = RUN;
    endcase
  end

  assign stall_inc = (state_reg == RUN || state_reg == MEM_WAIT) && !en[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg          <= RUN;
      wait_cnt_reg       <= '0;
      drain_cnt_reg      <= '0;
      stall_cycles_reg   <= '0;
      redirect_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      if (stall_inc) stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (redirect_inc && redirect_count_reg != 16'hFFFF)
        redirect_count_reg <= redirect_count_reg + 16'd1;
    end
  end

  // Everything is held quiet while reset is asserted.
  assign {pc_en, if_id_en, id_ex_en, ex_mem_en} = reset_n ? en : 4'b0000;
  assign if_id_flush    = reset_n & if_flush;
  assign id_ex_flush    = reset_n & id_flush;
  assign halted         = reset_n & (state_reg == HALT);
  assign fault          = reset_n & (state_reg == FAULT);
  assign stall_cycles   = stall_cycles_reg;
  assign redirect_count = redirect_count_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scenario bench for pipeline_ctrl: expected control vectors are queued when
// stimulus is driven and popped against the DUT outputs half a cycle later.
module tb_pipeline_ctrl;

  logic        clk;
  logic        reset_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
  logic        imem_ready, mem_req, dmem_ready, halt_req, resume;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush;
  logic        halted, fault;
  logic [31:0] stall_cycles;
  logic [15:0] redirect_count;
  logic [7:0]  outs;

  int n_vec = 0;
  int n_err = 0;
  int stall_exp = 0;
  int redir_exp = 0;

  string      name_q[$];
  logic [7:0] exp_q[$];

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, halted, fault}
  localparam logic [7:0] V_OFF   = 8'b0000_0000;
  localparam logic [7:0] V_RUN   = 8'b1111_0000;
  localparam logic [7:0] V_LU    = 8'b0011_0100;
  localparam logic [7:0] V_RED   = 8'b1111_1100;
  localparam logic [7:0] V_FRZ   = 8'b0000_0000;
  localparam logic [7:0] V_IMEM  = 8'b0111_1000;
  localparam logic [7:0] V_HREQ  = 8'b0111_1100;
  localparam logic [7:0] V_DRAIN = 8'b0111_1000;
  localparam logic [7:0] V_DFRZ  = 8'b0100_1000;
  localparam logic [7:0] V_HALT  = 8'b0000_0010;
  localparam logic [7:0] V_FAULT = 8'b0000_0001;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .DRAIN_CYCLES(3)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .ex_redirect    (ex_redirect),
    .imem_ready     (imem_ready),
    .mem_req        (mem_req),
    .dmem_ready     (dmem_ready),
    .halt_req       (halt_req),
    .resume         (resume),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .halted         (halted),
    .fault          (fault),
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count)
  );

  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, halted, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    imem_ready = 1'b1; mem_req = 1'b0; dmem_ready = 1'b1;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  // One clock of stimulus: queue the expectation, compare at negedge, return just after posedge.
  task automatic step(input string name, input logic [7:0] expected);
    string      nm;
    logic [7:0] ev;
    name_q.push_back(name);
    exp_q.push_back(expected);
    @(negedge clk);
    nm = name_q.pop_front();
    ev = exp_q.pop_front();
    n_vec++;
    if (outs !== ev) begin
      n_err++;
      $display("FAIL %s: outputs %b, required %b", nm, outs, ev);
    end else begin
      $display("vec %0d %s outputs %b", n_vec, nm, outs);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_idle();
    @(posedge clk); #1;
    step("reset_outputs", V_OFF);
    n_vec++;
    if (stall_cycles !== 32'd0 || redirect_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_counters: stall %0d redirect %0d, required 0 0", stall_cycles, redirect_count);
    end
    reset_n = 1'b1;
    step("first_run_cycle", V_RUN);
  endtask

  task automatic test_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    step("load_use_rs2", V_LU); stall_exp++;
    set_idle();
    step("after_load_use", V_RUN);
    n_vec++;
    if (stall_cycles !== 32'(stall_exp)) begin
      n_err++;
      $display("FAIL stall_after_lu: stall_cycles %0d, required %0d", stall_cycles, stall_exp);
    end
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    step("load_use_rs1", V_LU); stall_exp++;
    id_use_rs1 = 1'b0;
    step("rs1_not_used", V_RUN);
    set_idle();
  endtask

  task automatic test_rd_zero();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    step("load_x0_no_stall", V_RUN);
    ex_rd = 5'd5; id_rs2 = 5'd6;
    step("load_other_reg", V_RUN);
    set_idle();
  endtask

  task automatic test_redirect_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1; ex_redirect = 1'b1;
    step("redirect_beats_lu", V_RED); redir_exp++;
    set_idle();
    n_vec++;
    if (redirect_count !== 16'(redir_exp)) begin
      n_err++;
      $display("FAIL redirect_count: %0d, required %0d", redirect_count, redir_exp);
    end
  endtask

  task automatic test_imem_wait();
    imem_ready = 1'b0;
    step("imem_not_ready", V_IMEM); stall_exp++;
    set_idle();
  endtask

  task automatic test_mem_wait();
    mem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("mem_freeze", V_FRZ); stall_exp++;
    end
    ex_redirect = 1'b0; dmem_ready = 1'b1;
    step("mem_release", V_RUN);
    mem_req = 1'b0;
    step("mem_back_run", V_RUN);
    n_vec++;
    if (stall_cycles !== 32'(stall_exp) || redirect_count !== 16'(redir_exp)) begin
      n_err++;
      $display("FAIL mem_wait_counters: stall %0d redirect %0d, required %0d %0d",
               stall_cycles, redirect_count, stall_exp, redir_exp);
    end
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    step("halt_request", V_HREQ); stall_exp++;
    ex_redirect = 1'b1;
    step("drain_1_ignores", V_DRAIN);
    ex_redirect = 1'b0; halt_req = 1'b0; mem_req = 1'b1; dmem_ready = 1'b0;
    step("drain_mem_freeze", V_DFRZ);
    mem_req = 1'b0; dmem_ready = 1'b1;
    step("drain_2", V_DRAIN);
    step("drain_3", V_DRAIN);
    step("halted", V_HALT);
    resume = 1'b1;
    step("resume_pulse", V_HALT);
    resume = 1'b0;
    step("resumed_run", V_RUN);
    n_vec++;
    if (stall_cycles !== 32'(stall_exp) || redirect_count !== 16'(redir_exp)) begin
      n_err++;
      $display("FAIL halt_counters: stall %0d redirect %0d, required %0d %0d",
               stall_cycles, redirect_count, stall_exp, redir_exp);
    end
  endtask

  task automatic test_fault();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("timeout_freeze", V_FRZ); stall_exp++;
    end
    step("fault_set", V_FAULT);
    resume = 1'b1;
    step("fault_ignores_resume", V_FAULT);
    resume = 1'b0; dmem_ready = 1'b1;
    step("fault_sticky", V_FAULT);
    n_vec++;
    if (stall_cycles !== 32'(stall_exp)) begin
      n_err++;
      $display("FAIL fault_stall_count: %0d, required %0d", stall_cycles, stall_exp);
    end
    reset_n = 1'b0;
    step("fault_reset", V_OFF);
    stall_exp = 0; redir_exp = 0;
    reset_n = 1'b1; set_idle();
    step("after_fault_reset", V_RUN);
    n_vec++;
    if (stall_cycles !== 32'd0 || redirect_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset_clears_counters: stall %0d redirect %0d, required 0 0", stall_cycles, redirect_count);
    end
  endtask

  task automatic test_saturation();
    ex_redirect = 1'b1;
    repeat (65534) @(posedge clk);
    #1;
    n_vec++;
    if (redirect_count !== 16'hFFFE) begin
      n_err++;
      $display("FAIL redirect_near_max: %h, required fffe", redirect_count);
    end
    for (int i = 0; i < 3; i++) step("redirect_saturate", V_RED);
    set_idle();
    n_vec++;
    if (redirect_count !== 16'hFFFF || stall_cycles !== 32'd0) begin
      n_err++;
      $display("FAIL redirect_saturated: redirect %h stall %0d, required ffff 0", redirect_count, stall_cycles);
    end
  endtask

  initial begin
    set_idle();
    reset_n = 1'b0;
    test_reset();
    test_load_use();
    test_rd_zero();
    test_redirect_load_use();
    test_imem_wait();
    test_mem_wait();
    test_halt();
    test_fault();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
